icache_dm_wt: RTL and testbench
===============================

Name: icache_dm_wt

Overview:
- Parametrised direct-mapped, write-through, no-write-allocate data cache for the RISC-V microcontroller.
- Sits between the core's load/store unit and the backing RAM.
- Adds the features a bare cache array lacks: per-line valid bits, tag compare, a miss-fill FSM with a memory handshake, write-through, flush, and hit/miss counters.
- Addresses are byte addresses and accesses are word-aligned. Adr[1:0] is ignored.

Parameters:
- ADDR_W, 32, CPU/memory byte-address width.
- DATA_W, 32, word width.
- LINES, 128, number of one-word lines; must be a power of 2, at least 2.
- CNT_W, 16, width of the hit and miss counters.
- Derived: IDX_W = log2(LINES); TAG_W = ADDR_W - 2 - IDX_W.
- Index is Adr[IDX_W+1:2]. Tag is Adr[ADDR_W-1:IDX_W+2].

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous active-high reset.
- cpu_req  in  1  access request; held stable until cpu_ready.
- cpu_we  in  1  1 = store, 0 = load.
- cpu_adr  in  ADDR_W  byte address.
- cpu_wd  in  DATA_W  store data.
- cpu_rd  out  DATA_W  load data; valid only while cpu_ready=1.
- cpu_ready  out  1  one-cycle completion pulse.
- flush  in  1  invalidate all lines; honoured only in IDLE.
- mem_req  out  1  backing-memory request; held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_adr  out  ADDR_W  memory address (cpu_adr with [1:0] forced to 0).
- mem_wd  out  DATA_W  memory write data.
- mem_rd  in  DATA_W  memory read data; valid with mem_ack.
- mem_ack  in  1  one-cycle memory completion.
- hit_cnt  out  CNT_W  saturating count of load hits.
- miss_cnt  out  CNT_W  saturating count of load misses.

Behaviour:
- Storage: per line, a valid bit, a TAG_W tag and a DATA_W word.
- Reset (rst=1 at an edge):
  - All valid bits cleared; FSM goes to IDLE.
  - cpu_ready, mem_req, mem_we = 0; cpu_rd, mem_adr, mem_wd = 0; hit_cnt, miss_cnt = 0.
  - Reset mid-transaction abandons it: mem_req drops the next cycle, and no line is written.
- FSM states: IDLE, LOOKUP, FILL, WRITE, RESP.
- IDLE:
  - If flush=1, all valid bits are cleared at that edge and cpu_req is ignored that cycle.
  - Otherwise, if cpu_req=1, latch adr/we/wd and go to LOOKUP.
- LOOKUP: hit = valid[idx] && tag[idx]==latched tag.
  - Load hit: cpu_rd <= line data, hit_cnt++, go to RESP.
  - Load miss: miss_cnt++, assert mem_req (mem_we=0, mem_adr), go to FILL.
  - Store: assert mem_req with mem_we=1 and mem_wd=latched data, go to WRITE. Store hits and misses are not counted.
- FILL:
  - Hold mem_req/mem_adr until mem_ack.
  - On mem_ack: write the line (valid=1, tag, data=mem_rd), cpu_rd <= mem_rd, drop mem_req, go to RESP.
- WRITE:
  - Hold until mem_ack.
  - On ack: if the line hits, update its data (write-through); if it misses, leave the line unchanged (no allocate). Drop mem_req, go to RESP.
- RESP: cpu_ready=1 for exactly one cycle, go to IDLE. cpu_rd returns to 0 the cycle after RESP.
- Latency:
  - Load hit: cpu_ready 2 cycles after the cpu_req sampling edge.
  - Miss/store: 2 cycles + memory wait + 1.
- mem_ack outside FILL/WRITE is ignored.
- Counters saturate at all-ones and do not wrap.
- Back-to-back: the next cpu_req can be sampled in the IDLE cycle after RESP. A new request is never accepted while busy.

Test Plan:
- After reset, load 0x0000_0040 with memory returning 0xDEAD_BEEF after a 3-cycle ack delay -> one mem_req (mem_we=0, mem_adr=0x40). cpu_ready with cpu_rd=0xDEAD_BEEF. miss_cnt=1.
- Repeat the load of 0x40 -> no mem_req; cpu_ready 2 cycles after req with cpu_rd=0xDEAD_BEEF; hit_cnt=1.
- Store 0x1234_5678 to 0x40, then load 0x40 -> memory sees a write of 0x1234_5678; the load hits with 0x1234_5678 and issues no mem_req.
- Store to 0x80 (miss), then load 0x80 -> the store is written through; the load misses (no allocate); miss_cnt increments.
- Load 0x40 then load 0x240 (same index, LINES=128) -> second access misses and evicts. A reload of 0x40 misses again.
- Assert flush in IDLE, then load 0x40 -> miss. Assert rst during FILL -> mem_req=0 the next cycle, and a later load of the same address misses.

Source files
------------

// File: rtl/icache_dm_wt.sv
// Direct-mapped write-through data cache with miss-fill FSM,
// flush and saturating hit/miss counters.
`timescale 1ns/1ps
module icache_dm_wt #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LINES  = 128,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_adr,
  input  logic [DATA_W-1:0] cpu_wd,
  output logic [DATA_W-1:0] cpu_rd,
  output logic              cpu_ready,
  input  logic              flush,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_adr,
  output logic [DATA_W-1:0] mem_wd,
  input  logic [DATA_W-1:0] mem_rd,
  input  logic              mem_ack,
  output logic [CNT_W-1:0]  hit_cnt,
  output logic [CNT_W-1:0]  miss_cnt
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - 2 - IDX_W;
  localparam int WA_W  = ADDR_W - 2;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_FILL,
    S_WRITE,
    S_RESP
  } state_t;

  state_t r_state;
  state_t w_next;

  logic [WA_W-1:0]   r_wadr;
  logic              r_we;
  logic [DATA_W-1:0] r_wd;
  logic [LINES-1:0]  r_valid;
  logic [TAG_W-1:0]  r_tag  [LINES];
  logic [DATA_W-1:0] r_data [LINES];
  logic [DATA_W-1:0] r_rd;
  logic [ADDR_W-1:0] r_madr;
  logic [DATA_W-1:0] r_mwd;
  logic [CNT_W-1:0]  r_hit;
  logic [CNT_W-1:0]  r_miss;

  logic [IDX_W-1:0]  w_idx;
  logic [TAG_W-1:0]  w_tag;
  logic              w_hit;
  logic              w_unused;

  // Byte-offset bits carry no information for word accesses.
  assign w_unused = &{1'b0, cpu_adr[1:0]};

  assign w_idx = r_wadr[IDX_W-1:0];
  assign w_tag = r_wadr[WA_W-1:IDX_W];
  assign w_hit = r_valid[w_idx] &&
                 (r_tag[w_idx] == w_tag);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (!flush && cpu_req) w_next = S_LOOKUP;
      end
      S_LOOKUP: begin
        if (r_we)       w_next = S_WRITE;
        else if (w_hit) w_next = S_RESP;
        else            w_next = S_FILL;
      end
      S_FILL: begin
        if (mem_ack) w_next = S_RESP;
      end
      S_WRITE: begin
        if (mem_ack) w_next = S_RESP;
      end
      S_RESP: w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wadr  <= '0;
      r_we    <= 1'b0;
      r_wd    <= '0;
      r_valid <= '0;
      r_rd    <= '0;
      r_madr  <= '0;
      r_mwd   <= '0;
      r_hit   <= '0;
      r_miss  <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (flush) begin
            r_valid <= '0;
          end else if (cpu_req) begin
            r_wadr <= cpu_adr[ADDR_W-1:2];
            r_we   <= cpu_we;
            r_wd   <= cpu_wd;
          end
        end
        S_LOOKUP: begin
          r_madr <= {r_wadr, 2'b00};
          if (r_we) begin
            r_mwd <= r_wd;
          end else if (w_hit) begin
            r_rd <= r_data[w_idx];
            if (r_hit != '1) r_hit <= r_hit + 1'b1;
          end else begin
            if (r_miss != '1) r_miss <= r_miss + 1'b1;
          end
        end
        S_FILL: begin
          if (mem_ack) begin
            r_valid[w_idx] <= 1'b1;
            r_rd           <= mem_rd;
          end
        end
        S_RESP:  r_rd <= '0;
        default: ;
      endcase
    end
  end

  // Line storage has no reset; a reset edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && mem_ack) begin
      if (r_state == S_FILL) begin
        r_tag[w_idx]  <= w_tag;
        r_data[w_idx] <= mem_rd;
      end else if (r_state == S_WRITE && w_hit) begin
        r_data[w_idx] <= r_wd;
      end
    end
  end

  assign cpu_rd    = r_rd;
  assign cpu_ready = (r_state == S_RESP);
  assign mem_req   = (r_state == S_FILL) ||
                     (r_state == S_WRITE);
  assign mem_we    = (r_state == S_WRITE);
  assign mem_adr   = r_madr;
  assign mem_wd    = r_mwd;
  assign hit_cnt   = r_hit;
  assign miss_cnt  = r_miss;

endmodule

// File: tb/tb_icache_dm_wt.sv
// Scoreboard bench for icache_dm_wt: directed loads/stores
// against a behavioural backing memory.
`timescale 1ns/1ps
module tb_icache_dm_wt;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int CW = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          cpu_req;
  logic          cpu_we;
  logic [AW-1:0] cpu_adr;
  logic [DW-1:0] cpu_wd;
  logic [DW-1:0] cpu_rd;
  logic          cpu_ready;
  logic          flush;
  logic          mem_req;
  logic          mem_we;
  logic [AW-1:0] mem_adr;
  logic [DW-1:0] mem_wd;
  logic [DW-1:0] mem_rd;
  logic          mem_ack;
  logic [CW-1:0] hit_cnt;
  logic [CW-1:0] miss_cnt;

  always #5 clk = ~clk;

  icache_dm_wt #(
    .ADDR_W(AW),
    .DATA_W(DW),
    .LINES(128),
    .CNT_W(CW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cpu_req(cpu_req),
    .cpu_we(cpu_we),
    .cpu_adr(cpu_adr),
    .cpu_wd(cpu_wd),
    .cpu_rd(cpu_rd),
    .cpu_ready(cpu_ready),
    .flush(flush),
    .mem_req(mem_req),
    .mem_we(mem_we),
    .mem_adr(mem_adr),
    .mem_wd(mem_wd),
    .mem_rd(mem_rd),
    .mem_ack(mem_ack),
    .hit_cnt(hit_cnt),
    .miss_cnt(miss_cnt)
  );

  typedef struct {
    bit          chk_rd;
    logic [31:0] rd;
  } resp_t;

  typedef struct {
    bit          we;
    logic [31:0] adr;
    logic [31:0] wd;
  } mtx_t;

  resp_t       rq[$];
  mtx_t        mq[$];
  logic [31:0] mm [logic [31:0]];
  int          checks = 0;
  int          errors = 0;
  int          mdelay = 3;

  task automatic chk(string nm, logic [31:0] act,
                     logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h",
               nm, act, exp);
    end
  endtask

  function automatic logic [31:0] mread(logic [31:0] a);
    if (mm.exists(a)) return mm[a];
    return a ^ 32'h5A5A_0000;
  endfunction

  // Response monitor
  initial begin
    resp_t e;
    forever begin
      @(negedge clk);
      if (cpu_ready) begin
        if (rq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ready: rd %h expected none",
                   cpu_rd);
        end else begin
          e = rq.pop_front();
          if (e.chk_rd) chk("cpu_rd", cpu_rd, e.rd);
        end
      end
    end
  end

  // Backing memory: checks each request, acks after mdelay
  initial begin
    mtx_t        t;
    logic [31:0] a;
    mem_ack = 1'b0;
    mem_rd  = '0;
    forever begin
      @(negedge clk);
      if (mem_req) begin
        a = mem_adr;
        if (mq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_mem_req: adr %h expected none",
                   mem_adr);
        end else begin
          t = mq.pop_front();
          chk("mem_we", {31'd0, mem_we}, {31'd0, t.we});
          chk("mem_adr", mem_adr, t.adr);
          if (t.we) chk("mem_wd", mem_wd, t.wd);
        end
        if (mem_we) mm[a] = mem_wd;
        repeat (mdelay - 1) @(negedge clk);
        mem_rd  = mread(a);
        mem_ack = 1'b1;
        @(negedge clk);
        mem_ack = 1'b0;
        mem_rd  = '0;
      end
    end
  end

  task automatic access(bit we, logic [31:0] adr,
                        logic [31:0] wd, bit chk_rd,
                        logic [31:0] exp_rd, int exp_lat,
                        string nm);
    int    n;
    resp_t r;
    r.chk_rd = chk_rd;
    r.rd     = exp_rd;
    rq.push_back(r);
    cpu_req = 1'b1;
    cpu_we  = we;
    cpu_adr = adr;
    cpu_wd  = wd;
    @(posedge clk);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!cpu_ready && n < 60);
    if (!cpu_ready) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout: no ready after %0d cycles, required ready",
               nm, n);
    end else if (exp_lat > 0) begin
      chk({nm, "_lat"}, n, exp_lat);
    end
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    @(negedge clk);
    chk({nm, "_rd_clr"}, cpu_rd, 32'd0);
  endtask

  task automatic load_hit(logic [31:0] adr,
                          logic [31:0] d, string nm);
    access(1'b0, adr, '0, 1'b1, d, 2, nm);
  endtask

  task automatic load_miss(logic [31:0] adr,
                           logic [31:0] d, string nm);
    mtx_t t;
    t.we  = 1'b0;
    t.adr = adr;
    t.wd  = '0;
    mq.push_back(t);
    access(1'b0, adr, '0, 1'b1, d, 0, nm);
  endtask

  task automatic store(logic [31:0] adr,
                       logic [31:0] d, string nm);
    mtx_t t;
    t.we  = 1'b1;
    t.adr = adr;
    t.wd  = d;
    mq.push_back(t);
    access(1'b1, adr, d, 1'b0, '0, 0, nm);
  endtask

  task automatic cnts(int h, int m, string nm);
    chk({nm, "_hit_cnt"}, {29'd0, hit_cnt}, h);
    chk({nm, "_miss_cnt"}, {29'd0, miss_cnt}, m);
  endtask

  initial begin
    int   n;
    mtx_t t;
    rst     = 1'b1;
    cpu_req = 1'b0;
    cpu_we  = 1'b0;
    cpu_adr = '0;
    cpu_wd  = '0;
    flush   = 1'b0;
    mm[32'h40] = 32'hDEAD_BEEF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_ready", {31'd0, cpu_ready}, 32'd0);
    chk("rst_mem_req", {31'd0, mem_req}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_cpu_rd", cpu_rd, 32'd0);
    chk("rst_mem_adr", mem_adr, 32'd0);
    chk("rst_mem_wd", mem_wd, 32'd0);
    cnts(0, 0, "rst");
    rst = 1'b0;
    @(negedge clk);

    load_miss(32'h40, 32'hDEAD_BEEF, "ld40_miss");
    cnts(0, 1, "ld40_miss");
    load_hit(32'h40, 32'hDEAD_BEEF, "ld40_hit");
    cnts(1, 1, "ld40_hit");

    store(32'h40, 32'h1234_5678, "st40");
    cnts(1, 1, "st40");
    load_hit(32'h40, 32'h1234_5678, "ld40_after_st");
    cnts(2, 1, "ld40_after_st");

    store(32'h80, 32'hCAFE_F00D, "st80_miss");
    load_miss(32'h80, 32'hCAFE_F00D, "ld80_noalloc");
    cnts(2, 2, "ld80_noalloc");

    load_hit(32'h40, 32'h1234_5678, "ld40_pre_evict");
    load_miss(32'h240, 32'h5A5A_0240, "ld240_evict");
    load_miss(32'h40, 32'h1234_5678, "ld40_evicted");
    cnts(3, 4, "evict");

    load_hit(32'h40, 32'h1234_5678, "ld40_pre_flush");
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    @(negedge clk);
    load_miss(32'h40, 32'h1234_5678, "ld40_flushed");
    cnts(4, 5, "flush");

    // Abandon a fill with reset; the late ack must be ignored
    mdelay  = 20;
    t.we    = 1'b0;
    t.adr   = 32'h300;
    t.wd    = '0;
    mq.push_back(t);
    cpu_req = 1'b1;
    cpu_we  = 1'b0;
    cpu_adr = 32'h300;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!mem_req && n < 20);
    chk("fill_started", {31'd0, mem_req}, 32'd1);
    rst     = 1'b1;
    cpu_req = 1'b0;
    @(negedge clk);
    chk("rst_fill_mem_req", {31'd0, mem_req}, 32'd0);
    rst = 1'b0;
    cnts(0, 0, "rst_fill");
    repeat (25) @(negedge clk);
    mdelay = 3;
    load_miss(32'h300, 32'h5A5A_0300, "ld300_after_rst");
    cnts(0, 1, "ld300_after_rst");

    for (int i = 0; i < 9; i++)
      load_hit(32'h300, 32'h5A5A_0300, "ld300_sat");
    cnts(7, 1, "saturate");

    repeat (5) @(negedge clk);
    chk("resp_q_empty", rq.size(), 32'd0);
    chk("mem_q_empty", mq.size(), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
